// File: rtl/bcd_mux_display_if.sv
// Bus bundle for the BCD counter / multiplexed display block: control
// inputs (enable, direction, clear) and the counter and display outputs.
interface bcd_mux_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      en;
  logic                      up_dn;
  logic                      clear;
  logic [4*NUM_DIGITS-1:0]   count_bcd;
  logic                      wrap;
  logic [7:0]                seg_out;
  logic [NUM_DIGITS-1:0]     dig_sel;

  // Controller side: drives the controls, observes counter and display
  modport master (
    output en, up_dn, clear,
    input  count_bcd, wrap, seg_out, dig_sel
  );

  // Block side: consumes the controls, drives counter and display
  modport slave (
    input  en, up_dn, clear,
    output count_bcd, wrap, seg_out, dig_sel
  );
endinterface

// File: rtl/bcd_mux_display.sv
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment
// display driver. Count tick and digit-scan tick are derived from hwclk.
// All outputs are registered; display outputs follow the scan index and
// count with one cycle of latency.
module bcd_mux_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int TICK_PERIOD   = 12000000,
  parameter int SCAN_PERIOD   = 12000,
  parameter int COMMON_ANODE  = 0,
  parameter int BLANK_LEADING = 1
) (
  input  logic               hwclk,
  input  logic               rst_n,
  bcd_mux_display_if.slave   bus
);

  localparam int CW     = 4 * NUM_DIGITS;
  localparam int TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic              CA_EN     = COMMON_ANODE[0];
  localparam logic              BLANK_EN  = BLANK_LEADING[0];

  // Idle (reset) levels: nothing lit, no digit driven
  localparam logic [7:0]            SEG_IDLE = CA_EN ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = CA_EN ? {NUM_DIGITS{1'b0}}
                                                     : {NUM_DIGITS{1'b1}};

  // 7-segment code, a..g with a as MSB, active-high
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  tick_s;
  logic                  scan_end_s;
  logic [CW-1:0]         inc_s, dec_s;
  logic                  carry_s, borrow_s;
  logic [3:0]            digit_s;
  logic                  upper_zero_s;
  logic                  run_zero_s;
  logic                  blank_s;
  logic [7:0]            seg_raw_s;
  logic [NUM_DIGITS-1:0] dig_raw_s;

  // Free-running count-tick and scan-tick dividers plus the scan index
  always_comb begin
    tick_s     = (tick_q == TICK_LAST);
    scan_end_s = (scan_q == SCAN_LAST);
    if (tick_s) begin
      tick_d = {TICK_W{1'b0}};
    end else begin
      tick_d = tick_q + TICK_W'(1'b1);
    end
    if (scan_end_s) begin
      scan_d = {SCAN_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1'b1);
      end
    end else begin
      scan_d = scan_q + SCAN_W'(1'b1);
      idx_d  = idx_q;
    end
  end

  // Ripple BCD increment and decrement candidates; final carry/borrow
  // set means every digit was 9 (up) or 0 (down), i.e. a wrap-around
  always_comb begin
    inc_s    = count_q;
    dec_s    = count_q;
    carry_s  = 1'b1;
    borrow_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry_s) begin
        if (count_q[i*4 +: 4] >= 4'd9) begin
          inc_s[i*4 +: 4] = 4'd0;
        end else begin
          inc_s[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
          carry_s         = 1'b0;
        end
      end else begin
        inc_s[i*4 +: 4] = count_q[i*4 +: 4];
      end
      if (borrow_s) begin
        if (count_q[i*4 +: 4] == 4'd0) begin
          dec_s[i*4 +: 4] = 4'd9;
        end else begin
          dec_s[i*4 +: 4] = count_q[i*4 +: 4] - 4'd1;
          borrow_s        = 1'b0;
        end
      end else begin
        dec_s[i*4 +: 4] = count_q[i*4 +: 4];
      end
    end
  end

  // Count next-state: clear wins at any time, then enable, then direction
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = {CW{1'b0}};
    end else if (tick_s && bus.en) begin
      if (bus.up_dn) begin
        count_d = inc_s;
        wrap_d  = carry_s;
      end else begin
        count_d = dec_s;
        wrap_d  = borrow_s;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Display next-state: select the scanned digit, blank leading zeros,
  // then apply the board polarity
  always_comb begin
    digit_s      = 4'd0;
    upper_zero_s = 1'b0;
    run_zero_s   = 1'b1;
    dig_raw_s    = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero_s   = run_zero_s && (count_q[i*4 +: 4] == 4'd0);
      dig_raw_s[i] = (IDX_W'(i) == idx_q);
      if (IDX_W'(i) == idx_q) begin
        digit_s      = count_q[i*4 +: 4];
        upper_zero_s = run_zero_s;
      end else begin
        digit_s      = digit_s;
        upper_zero_s = upper_zero_s;
      end
    end
    blank_s = BLANK_EN && (idx_q != {IDX_W{1'b0}}) && upper_zero_s;
    if (blank_s) begin
      seg_raw_s = 8'h00;
    end else begin
      seg_raw_s = {1'b0, seg_code(digit_s)};
    end
    if (CA_EN) begin
      seg_d = ~seg_raw_s;
      dig_d = dig_raw_s;
    end else begin
      seg_d = seg_raw_s;
      dig_d = ~dig_raw_s;
    end
  end

  // Divider, scan index and counter state registers
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= {TICK_W{1'b0}};
      scan_q  <= {SCAN_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      count_q <= {CW{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Registered display drive so the pins never see decode glitches
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_IDLE;
      dig_q <= DIG_IDLE;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.seg_out   = seg_q;
  assign bus.dig_sel   = dig_q;

endmodule

// File: tb/tb_bcd_mux_display.sv
// Bench for bcd_mux_display: two instances share the controls, one with
// active-high segments and leading-zero blanking, one common-anode
// without blanking. A decimal reference model predicts every cycle's
// outputs into a queue that a negedge monitor pops and compares.
module tb_bcd_mux_display;

  localparam int N    = 3;
  localparam int TP   = 4;
  localparam int SP   = 2;
  localparam int MAXV = 999;

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;

  always #5 hwclk = ~hwclk;

  bcd_mux_display_if #(.NUM_DIGITS(N)) ifa ();
  bcd_mux_display_if #(.NUM_DIGITS(N)) ifb ();

  bcd_mux_display #(
    .NUM_DIGITS(N), .TICK_PERIOD(TP), .SCAN_PERIOD(SP),
    .COMMON_ANODE(0), .BLANK_LEADING(1)
  ) dut_a (
    .hwclk(hwclk), .rst_n(rst_n), .bus(ifa)
  );

  bcd_mux_display #(
    .NUM_DIGITS(N), .TICK_PERIOD(TP), .SCAN_PERIOD(SP),
    .COMMON_ANODE(1), .BLANK_LEADING(0)
  ) dut_b (
    .hwclk(hwclk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct {
    logic [11:0] cnt;
    logic        wrap;
    logic [7:0]  seg_a;
    logic [2:0]  dig_a;
    logic [7:0]  seg_b;
    logic [2:0]  dig_b;
  } exp_t;

  exp_t q[$];
  int   k = 0;        // posedges since reset release
  int   v = 0;        // model count as a plain decimal number
  int   n_checks = 0;
  int   n_fail   = 0;

  logic en_r = 1'b0, up_r = 1'b0, clr_r = 1'b0;

  int         pow10   [0:3] = '{1, 10, 100, 1000};
  logic [6:0] seg_tab [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic logic [11:0] to_bcd(input int val);
    logic [11:0] r;
    r = 12'h000;
    for (int d = 0; d < N; d++) r[d*4 +: 4] = 4'((val / pow10[d]) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic e, input logic u, input logic c);
    en_r = e; up_r = u; clr_r = c;
    ifa.en = e; ifa.up_dn = u; ifa.clear = c;
    ifb.en = e; ifb.up_dn = u; ifb.clear = c;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hwclk);
    #1;
  endtask

  // Step until the next posedge is a count tick (bounded by one period)
  task automatic align_tick();
    for (int i = 0; i < TP && ((k + 1) % TP) != 0; i++) cycles(1);
    check("align", 32'((k + 1) % TP), 32'd0);
  endtask

  // Reference model: predicts outputs registered at each posedge
  always @(posedge hwclk or negedge rst_n) begin
    exp_t e;
    int   nk, nv, idx, dg;
    logic w;
    if (!rst_n) begin
      k <= 0;
      v <= 0;
      q.delete();
    end else begin
      nk  = k + 1;
      idx = (k / SP) % N;
      dg  = (v / pow10[idx]) % 10;
      e.seg_a = ((idx > 0) && (v < pow10[idx])) ? 8'h00 : {1'b0, seg_tab[dg]};
      e.dig_a = ~(3'b001 << idx);
      e.seg_b = ~{1'b0, seg_tab[dg]};
      e.dig_b = 3'b001 << idx;
      nv = v;
      w  = 1'b0;
      if (clr_r) nv = 0;
      else if ((nk % TP) == 0 && en_r) begin
        if (up_r) begin
          if (v == MAXV) begin nv = 0; w = 1'b1; end
          else nv = v + 1;
        end else begin
          if (v == 0) begin nv = MAXV; w = 1'b1; end
          else nv = v - 1;
        end
      end
      e.cnt  = to_bcd(nv);
      e.wrap = w;
      q.push_back(e);
      k <= nk;
      v <= nv;
    end
  end

  // Monitor: compare both instances against the predicted entry
  always @(negedge hwclk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("count_a", 32'(ifa.count_bcd), 32'(e.cnt));
      check("wrap_a",  32'(ifa.wrap),      32'(e.wrap));
      check("seg_a",   32'(ifa.seg_out),   32'(e.seg_a));
      check("dig_a",   32'(ifa.dig_sel),   32'(e.dig_a));
      check("count_b", 32'(ifb.count_bcd), 32'(e.cnt));
      check("wrap_b",  32'(ifb.wrap),      32'(e.wrap));
      check("seg_b",   32'(ifb.seg_out),   32'(e.seg_b));
      check("dig_b",   32'(ifb.dig_sel),   32'(e.dig_b));
    end
  end

  task automatic check_reset_state();
    check("rst_count_a", 32'(ifa.count_bcd), 32'h000);
    check("rst_wrap_a",  32'(ifa.wrap),      32'd0);
    check("rst_seg_a",   32'(ifa.seg_out),   32'h00);
    check("rst_dig_a",   32'(ifa.dig_sel),   32'b111);
    check("rst_count_b", 32'(ifb.count_bcd), 32'h000);
    check("rst_seg_b",   32'(ifb.seg_out),   32'hFF);
    check("rst_dig_b",   32'(ifb.dig_sel),   32'b000);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0);
    cycles(3);
    check_reset_state();
    rst_n = 1'b1;

    // Down from 000 wraps to 999, then up from 999 wraps to 000
    set_in(1'b1, 1'b0, 1'b0);
    cycles(TP);
    check("dn_wrap", 32'(ifa.count_bcd), 32'h999);
    set_in(1'b1, 1'b1, 1'b0);
    cycles(TP);
    check("up_wrap", 32'(ifa.count_bcd), 32'h000);

    // Carry across digits: 099 -> 100, then borrow back and on to 105
    cycles(TP * 99);
    check("cnt_099", 32'(ifa.count_bcd), 32'h099);
    cycles(TP);
    check("cnt_100", 32'(ifa.count_bcd), 32'h100);
    set_in(1'b1, 1'b0, 1'b0);
    cycles(TP);
    check("cnt_099b", 32'(ifa.count_bcd), 32'h099);
    set_in(1'b1, 1'b1, 1'b0);
    cycles(TP * 6);
    check("cnt_105", 32'(ifa.count_bcd), 32'h105);

    // Hold for three ticks while the display scans
    set_in(1'b0, 1'b1, 1'b0);
    cycles(TP * 3);
    check("hold_105", 32'(ifa.count_bcd), 32'h105);

    // Clear off-tick, step down to 999, then clear on the wrapping tick
    set_in(1'b0, 1'b1, 1'b1);
    cycles(1);
    set_in(1'b0, 1'b1, 1'b0);
    check("clr_off_tick", 32'(ifa.count_bcd), 32'h000);
    align_tick();
    set_in(1'b1, 1'b0, 1'b0);
    cycles(1);
    set_in(1'b0, 1'b1, 1'b0);
    check("cnt_999", 32'(ifa.count_bcd), 32'h999);
    align_tick();
    set_in(1'b1, 1'b1, 1'b1);
    cycles(1);
    check("clr_tick_cnt",  32'(ifa.count_bcd), 32'h000);
    check("clr_tick_wrap", 32'(ifa.wrap),      32'd0);

    // Count to 008 and let both displays scan through
    set_in(1'b1, 1'b1, 1'b0);
    align_tick();
    cycles(TP * 8);
    set_in(1'b0, 1'b1, 1'b0);
    check("cnt_008", 32'(ifa.count_bcd), 32'h008);
    cycles(SP * N * 2);

    // Asynchronous reset in the middle of a tick period
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    cycles(2);
    rst_n = 1'b1;
    set_in(1'b1, 1'b1, 1'b0);
    cycles(TP - 1);
    check("no_tick_yet", 32'(ifa.count_bcd), 32'h000);
    cycles(1);
    check("first_tick", 32'(ifa.count_bcd), 32'h001);

    // Randomized controls
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
             ($urandom_range(49, 0) == 0));
      cycles(1);
    end

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
